lcd_bus_responder: RTL
======================

Name: lcd_bus_responder

Overview:
- Synthesizable HD44780-compatible responder: the LCD side of the parallel RS/RW/E/DATA bus that lcd_ctrl drives.
- Decodes instruction and data writes into display-control state and a 2x16 shadow DDRAM.
- Emulates execution busy time and answers busy-flag/address and data reads.
- Used as an on-chip mirror of the LCD contents (debug readout, bench scoreboard) and as a board-less stand-in for the panel.

Parameters:
- BUSY_CYC, 2000: busy duration of a normal instruction or data write, in clk cycles (40 us at 50 MHz).
- CLR_CYC, 76500: busy duration of Clear Display and Return Home, in clk cycles (1.53 ms).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset.
- i_lcd_rs  in  1  register select: 0 = instruction, 1 = data.
- i_lcd_rw  in  1  0 = write, 1 = read.
- i_lcd_e  in  1  enable strobe.
- i_lcd_data  in  8  bus data from the master.
- o_lcd_dout  out  8  read data driven back to the master.
- o_lcd_doe  out  1  read-data valid (output enable).
- o_busy  out  1  busy flag.
- o_ac  out  7  address counter.
- o_disp_on, o_cur_on, o_blink_on  out  1 each  Display Control bits D/C/B.
- o_dl8, o_two_line  out  1 each  Function Set bits DL/N.
- o_cmd_valid  out  1  one-cycle pulse for each accepted instruction write.
- o_cmd  out  8  last accepted instruction byte.
- o_err  out  1  one-cycle pulse for a write while busy, or a write to an invalid address.
- i_rd_addr  in  5  shadow read index: [4] = line, [3:0] = column.
- o_rd_char  out  8  shadow character at i_rd_addr, registered, 1-cycle latency.

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. All outputs reset to 0 except o_two_line=1 and o_dl8=1. Internal I/D=1, mode=DDRAM.
- Post-reset init: state INIT fills all 32 shadow entries with 0x20, one per cycle. o_busy=1 for those 32 cycles, then state goes to IDLE.
- Input sync: all bus inputs pass through 2-FF synchronizers. An access is the falling edge of synced E; RS, RW and DATA are taken from the same synced stage, one cycle before the falling edge.
- States: INIT, IDLE, CLEAR (32-cycle sweep), BUSY (countdown).
  - o_busy = 1 in INIT, CLEAR and BUSY.
  - A write in IDLE starts the countdown: BUSY_CYC, or CLR_CYC for 0x01-0x03. The clear sweep runs concurrently with the countdown.
- Write while o_busy: write is ignored, o_err pulses, state is unchanged.
- Instruction decode uses the highest set bit of DATA:
  - 0x01 Clear: sweep 0x20 into all entries, AC=0, I/D=1.
  - 0x02-0x03 Home: AC=0.
  - 0x04-0x07 Entry Mode: I/D=bit1. Bit S is stored in o_cmd only; display shift is not modelled.
  - 0x08-0x0F Display Control: D/C/B = bits 2/1/0.
  - 0x10-0x1F Shift: if bit3 = 0, AC steps ±1 by bit2 (1 = right/+1). If bit3 = 1 (display shift), AC is unchanged.
  - 0x20-0x3F Function Set: DL=bit4, N=bit3.
  - 0x40-0x7F CGRAM address: mode=CGRAM, AC=DATA[5:0].
  - 0x80-0xFF DDRAM address: mode=DDRAM, AC=DATA[6:0]. An address outside 0x00-0x27 and 0x40-0x67 pulses o_err; AC is still loaded.
- Data write (RS=1, RW=0):
  - Stores to the shadow only when mode=DDRAM and AC is in 0x00-0x0F or 0x40-0x4F. Index = {AC[6], AC[3:0]}.
  - In all other cases the data is discarded. AC always steps per I/D.
- AC wrap in 2-line mode:
  - +1: 0x27 -> 0x40, 0x67 -> 0x00.
  - -1: 0x00 -> 0x67, 0x40 -> 0x27.
- AC wrap in 1-line mode: 0x00-0x4F, wrapping modulo 80.
- CGRAM mode: AC wraps over 6 bits.
- Reads (RW=1):
  - o_lcd_doe = synced E & synced RW.
  - RS=0: o_lcd_dout = {o_busy, AC}, combinational from registered state. No side effect.
  - RS=1: o_lcd_dout = shadow[AC], or 0x20 outside the visible window. AC steps on the E falling edge.
  - Reads are always allowed, including while busy.
- o_cmd_valid and o_cmd update 1 cycle after the E falling edge. Data writes do not assert o_cmd_valid.
- The i_rd_addr port is independent of bus activity. During a sweep it may return old or 0x20 contents.

Decomposition:
- Package lcd_pkg holds:
  - instruction opcode constants (CLR, HOME, ENTRY, DISP, SHIFT, FUNC, CGADDR, DDADDR);
  - line base addresses 0x00 and 0x40;
  - AC wrap limits 0x27 and 0x67;
  - the state enum.
  lcd_ctrl shares this package.
- Sub-module lcd_ac_step: combinational next-AC from (ac, dir, two_line, mode).

Test Plan:
- Reset release -> o_busy=1 for 32 cycles, then all 32 o_rd_char reads = 0x20, o_ac=0.
- Write 0x80, wait, write data 'A','B' -> entry 0=0x41, entry 1=0x42, o_ac=0x02; o_busy high for BUSY_CYC after each write.
- Write 0x8F then data 0x5A twice -> entry 15=0x5A, AC passes 0x10 (no store) and ends at 0x11. Write 0xA7, data, data -> AC goes 0x27 -> 0x40 -> 0x41.
- Write 0x0C, then a second write 10 cycles later -> o_disp_on=1, o_cur_on=0, o_blink_on=0; o_err pulses once and the second write has no effect.
- Write 0x01 -> o_busy high for CLR_CYC, all entries = 0x20, AC=0. A read with RS=0 mid-busy -> o_lcd_dout[7]=1, o_lcd_doe=1.
- Write 0x04 (I/D=0), 0xC0, then data -> AC wraps 0x40 -> 0x27. Assert rst during a sweep -> outputs return to their reset values immediately, and INIT restarts.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared HD44780 bus definitions for lcd_ctrl and lcd_bus_responder
package lcd_pkg;

    // Instruction classes, identified by the highest set bit of the byte
    localparam logic [7:0] OP_CLR    = 8'h01;
    localparam logic [7:0] OP_HOME   = 8'h02;
    localparam logic [7:0] OP_ENTRY  = 8'h04;
    localparam logic [7:0] OP_DISP   = 8'h08;
    localparam logic [7:0] OP_SHIFT  = 8'h10;
    localparam logic [7:0] OP_FUNC   = 8'h20;
    localparam logic [7:0] OP_CGADDR = 8'h40;
    localparam logic [7:0] OP_DDADDR = 8'h80;

    // DDRAM line bases and the last address of each line in 2-line mode
    localparam logic [6:0] LINE0_BASE    = 7'h00;
    localparam logic [6:0] LINE1_BASE    = 7'h40;
    localparam logic [6:0] LINE0_LAST    = 7'h27;
    localparam logic [6:0] LINE1_LAST    = 7'h67;
    localparam logic [6:0] ONE_LINE_LAST = 7'h4F;

    localparam logic [7:0] CHAR_BLANK = 8'h20;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_CLEAR,
        ST_BUSY
    } lcd_state_t;

    typedef enum logic {
        MODE_DDRAM,
        MODE_CGRAM
    } lcd_mode_t;

    // Reduce an instruction byte to its one-hot class (0 for 0x00)
    function automatic logic [7:0] op_class(input logic [7:0] d);
        op_class = 8'h00;
        for (int b = 0; b < 8; b++) begin
            if (d[b]) begin
                op_class    = 8'h00;
                op_class[b] = 1'b1;
            end
        end
    endfunction

    // The first 16 columns of each line are mirrored in the shadow
    function automatic logic in_window(input logic [6:0] a);
        return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
    endfunction

    function automatic logic [4:0] shadow_idx(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    function automatic logic dd_addr_valid(input logic [6:0] a);
        return (a <= LINE0_LAST) || ((a >= LINE1_BASE) && (a <= LINE1_LAST));
    endfunction

endpackage

// File: rtl/lcd_ac_step.sv
// rtl/lcd_ac_step.sv - next address-counter value for one increment or decrement
module lcd_ac_step
    import lcd_pkg::*;
(
    input  logic       [6:0] ac,
    input  logic             dir,
    input  logic             two_line,
    input  lcd_mode_t        mode,
    output logic       [6:0] ac_next
);

    // CGRAM wraps over 6 bits; DDRAM hops between line ranges or wraps mod 80
    always_comb begin
        ac_next = ac;
        if (mode == MODE_CGRAM) begin
            ac_next = {1'b0, dir ? (ac[5:0] + 6'd1) : (ac[5:0] - 6'd1)};
        end else if (two_line) begin
            if (dir) begin
                if (ac == LINE0_LAST)      ac_next = LINE1_BASE;
                else if (ac == LINE1_LAST) ac_next = LINE0_BASE;
                else                       ac_next = ac + 7'd1;
            end else begin
                if (ac == LINE0_BASE)      ac_next = LINE1_LAST;
                else if (ac == LINE1_BASE) ac_next = LINE0_LAST;
                else                       ac_next = ac - 7'd1;
            end
        end else begin
            if (dir) ac_next = (ac >= ONE_LINE_LAST) ? 7'h00 : ac + 7'd1;
            else     ac_next = (ac == 7'h00) ? ONE_LINE_LAST : ac - 7'd1;
        end
    end

endmodule

// File: rtl/lcd_bus_responder.sv
// rtl/lcd_bus_responder.sv - HD44780-compatible bus responder with 2x16 shadow DDRAM
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYC = 2000,
    parameter int CLR_CYC  = 76500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_lcd_rs,
    input  logic       i_lcd_rw,
    input  logic       i_lcd_e,
    input  logic [7:0] i_lcd_data,
    output logic [7:0] o_lcd_dout,
    output logic       o_lcd_doe,
    output logic       o_busy,
    output logic [6:0] o_ac,
    output logic       o_disp_on,
    output logic       o_cur_on,
    output logic       o_blink_on,
    output logic       o_dl8,
    output logic       o_two_line,
    output logic       o_cmd_valid,
    output logic [7:0] o_cmd,
    output logic       o_err,
    input  logic [4:0] i_rd_addr,
    output logic [7:0] o_rd_char
);

    localparam int MAX_CYC = (BUSY_CYC > CLR_CYC) ? BUSY_CYC : CLR_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Bus bundle layout: {rs, rw, e, data}
    logic [10:0]      bus_s1, bus_s2, bus_d;
    lcd_state_t       state;
    lcd_mode_t        mode;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       sweep_idx;
    logic [6:0]       ac, ac_next;
    logic             id;
    logic [7:0]       shadow [32];
    logic             mem_we;
    logic [4:0]       mem_idx;
    logic [7:0]       mem_wdata;
    logic             e_fall, acc_rs, acc_rw;
    logic [7:0]       acc_data;
    logic             busy_int, wr_acc, wr_rej, rd_step, is_shift, step_dir;

    // Two-flop synchroniser plus one delay stage for E falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_s1 <= '0;
            bus_s2 <= '0;
            bus_d  <= '0;
        end else begin
            bus_s1 <= {i_lcd_rs, i_lcd_rw, i_lcd_e, i_lcd_data};
            bus_s2 <= bus_s1;
            bus_d  <= bus_s2;
        end
    end

    // RS/RW/DATA come from the cycle before E dropped, so they are stable
    assign e_fall   = bus_d[8] & ~bus_s2[8];
    assign acc_rs   = bus_d[10];
    assign acc_rw   = bus_d[9];
    assign acc_data = bus_d[7:0];

    // o_busy trails state by a cycle; either one being set blocks writes
    assign busy_int = (state != ST_IDLE) | o_busy;
    assign wr_acc   = e_fall & ~acc_rw & ~busy_int;
    assign wr_rej   = e_fall & ~acc_rw & busy_int;
    assign rd_step  = e_fall & acc_rw & acc_rs;
    assign is_shift = ~acc_rs & (acc_data[7:4] == 4'b0001);
    assign step_dir = is_shift ? acc_data[2] : id;

    lcd_ac_step u_ac_step (
        .ac       (ac),
        .dir      (step_dir),
        .two_line (o_two_line),
        .mode     (mode),
        .ac_next  (ac_next)
    );

    assign o_ac = ac;

    // Read data back to the master, valid while synced E and RW are both high
    always_comb begin
        o_lcd_doe  = bus_s2[8] & bus_s2[9];
        o_lcd_dout = 8'h00;
        if (o_lcd_doe) begin
            if (!bus_s2[10])                                o_lcd_dout = {o_busy, ac};
            else if ((mode == MODE_DDRAM) && in_window(ac)) o_lcd_dout = shadow[shadow_idx(ac)];
            else                                            o_lcd_dout = CHAR_BLANK;
        end
    end

    // Shadow write source: blank sweep during INIT/CLEAR, otherwise visible data writes
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = sweep_idx;
        mem_wdata = CHAR_BLANK;
        if ((state == ST_INIT) || (state == ST_CLEAR)) begin
            mem_we = 1'b1;
        end else if (wr_acc && acc_rs && (mode == MODE_DDRAM) && in_window(ac)) begin
            mem_we    = 1'b1;
            mem_idx   = shadow_idx(ac);
            mem_wdata = acc_data;
        end
    end

    // Shadow storage; INIT fills it after every reset, so it needs no reset itself
    always_ff @(posedge clk) begin
        if (mem_we) shadow[mem_idx] <= mem_wdata;
    end

    // Independent registered readout port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_rd_char <= 8'h00;
        else     o_rd_char <= shadow[i_rd_addr];
    end

    // Main controller: sweeps, busy countdown, instruction and data decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            cnt         <= '0;
            sweep_idx   <= '0;
            ac          <= LINE0_BASE;
            id          <= 1'b1;
            mode        <= MODE_DDRAM;
            o_disp_on   <= 1'b0;
            o_cur_on    <= 1'b0;
            o_blink_on  <= 1'b0;
            o_dl8       <= 1'b1;
            o_two_line  <= 1'b1;
            o_cmd_valid <= 1'b0;
            o_cmd       <= 8'h00;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_busy      <= (state != ST_IDLE);
            o_cmd_valid <= 1'b0;
            o_err       <= wr_rej;
            if (rd_step) ac <= ac_next;
            case (state)
                ST_INIT: begin
                    sweep_idx <= sweep_idx + 5'd1;
                    if (sweep_idx == 5'd31) state <= ST_IDLE;
                end
                ST_CLEAR: begin
                    sweep_idx <= sweep_idx + 5'd1;
                    if (cnt != '0) cnt <= cnt - CNT_ONE;
                    if (sweep_idx == 5'd31) state <= (cnt == '0) ? ST_IDLE : ST_BUSY;
                end
                ST_BUSY: begin
                    if (cnt == '0) state <= ST_IDLE;
                    else           cnt   <= cnt - CNT_ONE;
                end
                ST_IDLE: begin
                    if (wr_acc) begin
                        state <= ST_BUSY;
                        cnt   <= BUSY_LOAD;
                        if (acc_rs) begin
                            ac <= ac_next;
                        end else begin
                            o_cmd_valid <= 1'b1;
                            o_cmd       <= acc_data;
                            case (op_class(acc_data))
                                OP_CLR: begin
                                    state     <= ST_CLEAR;
                                    cnt       <= CLR_LOAD;
                                    sweep_idx <= '0;
                                    ac        <= LINE0_BASE;
                                    id        <= 1'b1;
                                    mode      <= MODE_DDRAM;
                                end
                                OP_HOME: begin
                                    cnt  <= CLR_LOAD;
                                    ac   <= LINE0_BASE;
                                    mode <= MODE_DDRAM;
                                end
                                OP_ENTRY: id <= acc_data[1];
                                OP_DISP: begin
                                    o_disp_on  <= acc_data[2];
                                    o_cur_on   <= acc_data[1];
                                    o_blink_on <= acc_data[0];
                                end
                                OP_SHIFT: begin
                                    if (!acc_data[3]) ac <= ac_next;
                                end
                                OP_FUNC: begin
                                    o_dl8      <= acc_data[4];
                                    o_two_line <= acc_data[3];
                                end
                                OP_CGADDR: begin
                                    mode <= MODE_CGRAM;
                                    ac   <= {1'b0, acc_data[5:0]};
                                end
                                OP_DDADDR: begin
                                    mode <= MODE_DDRAM;
                                    ac   <= acc_data[6:0];
                                    if (!dd_addr_valid(acc_data[6:0])) o_err <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
